poker_dealer_betting_round: RTL and testbench
=============================================

Name: poker_dealer_betting_round

Overview:
- Dealer-side controller for one heads-up betting round; consumes the output_valid/action/make_bet handshake of two poker_player_base bots.
- Drives each bot's dealer_request_action, dealer_acknowledge, invalid_move, action_opponent, bet_opponent, money_left, pot_size and betting_round_done.
- Validates each move, updates stacks, contributions and pot, and signals round completion or fold.
- Instantiated once per table, beside the card dealer; the hand sequencer pulses start_round once per street.

Parameters:
MIN_BET, 8'd2, minimum opening bet and minimum raise increment
MAX_INVALID, 2'd3, illegal moves tolerated per turn before a forced fold
RESP_TIMEOUT, 8'd255, cycles to wait for output_valid before a forced fold

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start_round  in  1  begin a round; sampled only in IDLE
first_player  in  1  player acting first, latched with start_round
stack0_in, stack1_in  in  8 each  stacks, loaded on start_round
pot_in  in  8  pot carried in, loaded on start_round
p0_output_valid, p1_output_valid  in  1 each  bot action valid
p0_action, p1_action  in  3 each  bot action code
p0_make_bet, p1_make_bet  in  8 each  bot chip amount
p0_request, p1_request  out  1 each  dealer_request_action to each bot
p0_ack, p1_ack  out  1 each  dealer_acknowledge to each bot
p0_invalid, p1_invalid  out  1 each  invalid_move pulse to each bot
p0_action_opponent, p1_action_opponent  out  3 each  opponent's last legal action
p0_bet_opponent, p1_bet_opponent  out  8 each  chips the opponent committed in its last legal action
money0, money1  out  8 each  current stacks
pot_size  out  8  current pot
betting_round_done  out  1  one-cycle pulse; round complete, no fold
hand_over  out  1  one-cycle pulse; a player folded
winner  out  1  non-folding player; valid with hand_over, held until the next start_round

Behaviour:
- Action codes: NO_ACTION 000, FOLD 001, CHECK 010, ALL_IN 011, CALL 100, BET 110, RAISE 111; 101 is illegal.
- Reset values: all outputs 0, action_opponent outputs NO_ACTION, state IDLE.
- Reset mid-round discards the round entirely.
- States: IDLE, REQUEST, CHECK, ACK, REJECT, SWITCH, DONE, FOLDED.
- IDLE -> REQUEST on start_round:
  - load stacks and pot; cur = first_player;
  - clear contrib0/contrib1, acted flags, invalid and timeout counters;
  - set action_opponent outputs to NO_ACTION.
- REQUEST:
  - hold pN_request high for the current player; the timeout counter increments each cycle.
  - On pN_output_valid: latch action and bet, drop request, go CHECK.
  - On counter == RESP_TIMEOUT: forced FOLD by cur.
- CHECK (one cycle): to_call = contrib_other - contrib_cur (8-bit, never negative). Legality:
  - FOLD: always legal.
  - CHECK: to_call == 0.
  - CALL: to_call > 0 and stack >= to_call; amount = to_call.
  - BET: to_call == 0, MIN_BET <= make_bet <= stack; amount = make_bet.
  - RAISE: to_call > 0, to_call + MIN_BET <= make_bet <= stack; amount = make_bet.
  - ALL_IN: stack > 0; amount = stack.
  - NO_ACTION or 101: illegal.
- Legal move -> ACK:
  - assert pN_ack until pN_output_valid falls;
  - on the fall: stack -= amount, contrib_cur += amount, pot += amount (saturates at 8'hFF), set acted_cur;
  - update the opponent's action_opponent and bet_opponent (= amount).
- Illegal move -> REJECT:
  - assert pN_ack until valid falls, then pulse pN_invalid for 1 cycle and increment the invalid counter;
  - return to REQUEST for the same player;
  - when the counter reaches MAX_INVALID: forced FOLD instead.
- State changes are applied after ACK, in the cycle valid falls. Then:
  - FOLD -> FOLDED: hand_over pulse; winner = other player.
  - Round done -> DONE when: (a) both players acted and contrib0 == contrib1 after CHECK/CALL; or (b) ALL_IN with new contrib_cur <= contrib_other; or (c) the opponent's stack is 0 and contribs are equal.
  - Otherwise -> SWITCH: cur flips, timeout and invalid counters clear, -> REQUEST.
- DONE: betting_round_done pulse, then IDLE.
- FOLDED: 1-cycle state, then IDLE.
- Each turn's request-to-REQUEST re-entry takes at least 4 cycles.
- Only the current player's valid is observed; the other player's valid is ignored.
- start_round outside IDLE is ignored.

Test Plan:
- Stacks 100/100, pot 0, first 0. P0 CHECK, P1 CHECK -> betting_round_done pulse; pot 0; money 100/100; p0_action_opponent = CHECK.
- Stacks 100/100. P0 BET 10, P1 CALL -> pot 20, money 90/90, done pulse; p0_bet_opponent = 10.
- P0 BET 10, P1 RAISE 11 (< 10+MIN_BET) -> p1_ack then p1_invalid pulse, p1_request reasserted, state unchanged. P1 then RAISE 12 -> accepted; P0 CALL -> pot 24, money 88/88, done.
- P1 never asserts valid after P0 BET 5 -> after 255 cycles, hand_over pulse, winner = 0, pot 5.
- Stacks 30/100. P0 BET 10, P1 RAISE 50, P0 ALL_IN (20) -> contrib 30 vs 50 -> done; pot 80, money0 0.
- Three consecutive NO_ACTION from P0 -> three invalid pulses, then hand_over, winner = 1; a reset pulse mid-REQUEST returns all outputs to reset values.

Source files
------------

// File: rtl/poker_dealer_betting_round.sv
// rtl/poker_dealer_betting_round.sv - dealer controller for one heads-up betting round
module poker_dealer_betting_round #(
    parameter logic [7:0] MIN_BET      = 8'd2,
    parameter logic [1:0] MAX_INVALID  = 2'd3,
    parameter logic [7:0] RESP_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_round,
    input  logic       first_player,
    input  logic [7:0] stack0_in,
    input  logic [7:0] stack1_in,
    input  logic [7:0] pot_in,
    input  logic       p0_output_valid,
    input  logic       p1_output_valid,
    input  logic [2:0] p0_action,
    input  logic [2:0] p1_action,
    input  logic [7:0] p0_make_bet,
    input  logic [7:0] p1_make_bet,
    output logic       p0_request,
    output logic       p1_request,
    output logic       p0_ack,
    output logic       p1_ack,
    output logic       p0_invalid,
    output logic       p1_invalid,
    output logic [2:0] p0_action_opponent,
    output logic [2:0] p1_action_opponent,
    output logic [7:0] p0_bet_opponent,
    output logic [7:0] p1_bet_opponent,
    output logic [7:0] money0,
    output logic [7:0] money1,
    output logic [7:0] pot_size,
    output logic       betting_round_done,
    output logic       hand_over,
    output logic       winner
);
    localparam logic [2:0] A_NONE  = 3'b000;
    localparam logic [2:0] A_FOLD  = 3'b001;
    localparam logic [2:0] A_CHECK = 3'b010;
    localparam logic [2:0] A_ALLIN = 3'b011;
    localparam logic [2:0] A_CALL  = 3'b100;
    localparam logic [2:0] A_BET   = 3'b110;
    localparam logic [2:0] A_RAISE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_CHECK, S_ACK, S_REJECT, S_SWITCH, S_DONE, S_FOLDED
    } state_t;

    state_t     state_q, state_d;
    logic       cur_q, cur_d;
    logic [7:0] stack0_q, stack0_d, stack1_q, stack1_d, pot_q, pot_d;
    logic [7:0] contrib0_q, contrib0_d, contrib1_q, contrib1_d;
    logic       acted0_q, acted0_d, acted1_q, acted1_d;
    logic [1:0] inv_cnt_q, inv_cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] act_q, act_d;
    logic [7:0] bet_q, bet_d;
    logic [2:0] aop0_q, aop0_d, aop1_q, aop1_d;
    logic [7:0] bop0_q, bop0_d, bop1_q, bop1_d;
    logic       inv0_q, inv0_d, inv1_q, inv1_d;
    logic       winner_q, winner_d;

    logic       cur_valid, legal, acted_oth, round_end;
    logic [7:0] stack_cur, stack_oth, contrib_cur, contrib_oth, to_call, amount, new_contrib;
    logic [8:0] pot_sum;

    always_comb begin
        cur_valid   = cur_q ? p1_output_valid : p0_output_valid;
        stack_cur   = cur_q ? stack1_q : stack0_q;
        stack_oth   = cur_q ? stack0_q : stack1_q;
        contrib_cur = cur_q ? contrib1_q : contrib0_q;
        contrib_oth = cur_q ? contrib0_q : contrib1_q;
        acted_oth   = cur_q ? acted0_q : acted1_q;
        to_call     = (contrib_oth > contrib_cur) ? (contrib_oth - contrib_cur) : 8'd0;

        legal  = 1'b0;
        amount = 8'd0;
        case (act_q)
            A_FOLD:  legal = 1'b1;
            A_CHECK: legal = (to_call == 8'd0);
            A_CALL: begin
                legal  = (to_call != 8'd0) && (stack_cur >= to_call);
                amount = to_call;
            end
            A_BET: begin
                legal  = (to_call == 8'd0) && (bet_q >= MIN_BET) && (bet_q <= stack_cur);
                amount = bet_q;
            end
            A_RAISE: begin
                legal  = (to_call != 8'd0) && (bet_q <= stack_cur) &&
                         (({1'b0, to_call} + {1'b0, MIN_BET}) <= {1'b0, bet_q});
                amount = bet_q;
            end
            A_ALLIN: begin
                legal  = (stack_cur != 8'd0);
                amount = stack_cur;
            end
            default: legal = 1'b0;
        endcase

        new_contrib = contrib_cur + amount;
        pot_sum     = {1'b0, pot_q} + {1'b0, amount};
        round_end   = (acted_oth && (new_contrib == contrib_oth) &&
                       (act_q == A_CHECK || act_q == A_CALL)) ||
                      ((act_q == A_ALLIN) && (new_contrib <= contrib_oth)) ||
                      ((stack_oth == 8'd0) && (new_contrib == contrib_oth));
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        stack0_d   = stack0_q;
        stack1_d   = stack1_q;
        pot_d      = pot_q;
        contrib0_d = contrib0_q;
        contrib1_d = contrib1_q;
        acted0_d   = acted0_q;
        acted1_d   = acted1_q;
        inv_cnt_d  = inv_cnt_q;
        tmo_d      = tmo_q;
        act_d      = act_q;
        bet_d      = bet_q;
        aop0_d     = aop0_q;
        aop1_d     = aop1_q;
        bop0_d     = bop0_q;
        bop1_d     = bop1_q;
        inv0_d     = 1'b0;
        inv1_d     = 1'b0;
        winner_d   = winner_q;

        case (state_q)
            S_IDLE: begin
                if (start_round) begin
                    stack0_d   = stack0_in;
                    stack1_d   = stack1_in;
                    pot_d      = pot_in;
                    cur_d      = first_player;
                    contrib0_d = 8'd0;
                    contrib1_d = 8'd0;
                    acted0_d   = 1'b0;
                    acted1_d   = 1'b0;
                    inv_cnt_d  = 2'd0;
                    tmo_d      = 8'd0;
                    aop0_d     = A_NONE;
                    aop1_d     = A_NONE;
                    winner_d   = 1'b0;
                    state_d    = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (cur_valid) begin
                    act_d   = cur_q ? p1_action : p0_action;
                    bet_d   = cur_q ? p1_make_bet : p0_make_bet;
                    state_d = S_CHECK;
                end else if (tmo_q == RESP_TIMEOUT) begin
                    winner_d = ~cur_q;
                    state_d  = S_FOLDED;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_CHECK: state_d = legal ? S_ACK : S_REJECT;
            S_ACK: begin
                // Bookkeeping lands only once the bot has released its valid.
                if (!cur_valid) begin
                    pot_d = pot_sum[8] ? 8'hFF : pot_sum[7:0];
                    if (cur_q) begin
                        stack1_d   = stack1_q - amount;
                        contrib1_d = new_contrib;
                        acted1_d   = 1'b1;
                        aop0_d     = act_q;
                        bop0_d     = amount;
                    end else begin
                        stack0_d   = stack0_q - amount;
                        contrib0_d = new_contrib;
                        acted0_d   = 1'b1;
                        aop1_d     = act_q;
                        bop1_d     = amount;
                    end
                    if (act_q == A_FOLD) begin
                        winner_d = ~cur_q;
                        state_d  = S_FOLDED;
                    end else if (round_end) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SWITCH;
                    end
                end
            end
            S_REJECT: begin
                if (!cur_valid) begin
                    inv0_d    = ~cur_q;
                    inv1_d    = cur_q;
                    inv_cnt_d = inv_cnt_q + 2'd1;
                    tmo_d     = 8'd0;
                    if (inv_cnt_q + 2'd1 == MAX_INVALID) begin
                        winner_d = ~cur_q;
                        state_d  = S_FOLDED;
                    end else begin
                        state_d = S_REQUEST;
                    end
                end
            end
            S_SWITCH: begin
                cur_d     = ~cur_q;
                tmo_d     = 8'd0;
                inv_cnt_d = 2'd0;
                state_d   = S_REQUEST;
            end
            S_DONE:   state_d = S_IDLE;
            S_FOLDED: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cur_q      <= 1'b0;
            stack0_q   <= 8'd0;
            stack1_q   <= 8'd0;
            pot_q      <= 8'd0;
            contrib0_q <= 8'd0;
            contrib1_q <= 8'd0;
            acted0_q   <= 1'b0;
            acted1_q   <= 1'b0;
            inv_cnt_q  <= 2'd0;
            tmo_q      <= 8'd0;
            act_q      <= A_NONE;
            bet_q      <= 8'd0;
            aop0_q     <= A_NONE;
            aop1_q     <= A_NONE;
            bop0_q     <= 8'd0;
            bop1_q     <= 8'd0;
            inv0_q     <= 1'b0;
            inv1_q     <= 1'b0;
            winner_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            stack0_q   <= stack0_d;
            stack1_q   <= stack1_d;
            pot_q      <= pot_d;
            contrib0_q <= contrib0_d;
            contrib1_q <= contrib1_d;
            acted0_q   <= acted0_d;
            acted1_q   <= acted1_d;
            inv_cnt_q  <= inv_cnt_d;
            tmo_q      <= tmo_d;
            act_q      <= act_d;
            bet_q      <= bet_d;
            aop0_q     <= aop0_d;
            aop1_q     <= aop1_d;
            bop0_q     <= bop0_d;
            bop1_q     <= bop1_d;
            inv0_q     <= inv0_d;
            inv1_q     <= inv1_d;
            winner_q   <= winner_d;
        end
    end

    assign p0_request         = (state_q == S_REQUEST) && !cur_q;
    assign p1_request         = (state_q == S_REQUEST) && cur_q;
    assign p0_ack             = (state_q == S_ACK || state_q == S_REJECT) && !cur_q;
    assign p1_ack             = (state_q == S_ACK || state_q == S_REJECT) && cur_q;
    assign p0_invalid         = inv0_q;
    assign p1_invalid         = inv1_q;
    assign p0_action_opponent = aop0_q;
    assign p1_action_opponent = aop1_q;
    assign p0_bet_opponent    = bop0_q;
    assign p1_bet_opponent    = bop1_q;
    assign money0             = stack0_q;
    assign money1             = stack1_q;
    assign pot_size           = pot_q;
    assign betting_round_done = (state_q == S_DONE);
    assign hand_over          = (state_q == S_FOLDED);
    assign winner             = winner_q;
endmodule

// File: tb/tb_poker_dealer_betting_round.sv
// tb/tb_poker_dealer_betting_round.sv - directed scoreboard bench for poker_dealer_betting_round
module tb_poker_dealer_betting_round;
    localparam logic [2:0] A_NONE  = 3'b000;
    localparam logic [2:0] A_FOLD  = 3'b001;
    localparam logic [2:0] A_CHECK = 3'b010;
    localparam logic [2:0] A_ALLIN = 3'b011;
    localparam logic [2:0] A_CALL  = 3'b100;
    localparam logic [2:0] A_BET   = 3'b110;
    localparam logic [2:0] A_RAISE = 3'b111;

    localparam int K_DONE = 0, K_HAND = 1, K_INV0 = 2, K_INV1 = 3;

    logic       clk, rst, start_round, first_player;
    logic [7:0] stack0_in, stack1_in, pot_in;
    logic       p0_output_valid, p1_output_valid;
    logic [2:0] p0_action, p1_action;
    logic [7:0] p0_make_bet, p1_make_bet;
    logic       p0_request, p1_request, p0_ack, p1_ack, p0_invalid, p1_invalid;
    logic [2:0] p0_action_opponent, p1_action_opponent;
    logic [7:0] p0_bet_opponent, p1_bet_opponent, money0, money1, pot_size;
    logic       betting_round_done, hand_over, winner;

    typedef struct {
        int         kind;
        logic [7:0] pot;
        logic [7:0] m0;
        logic [7:0] m1;
        logic       win;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    poker_dealer_betting_round dut (
        .clk(clk), .rst(rst), .start_round(start_round), .first_player(first_player),
        .stack0_in(stack0_in), .stack1_in(stack1_in), .pot_in(pot_in),
        .p0_output_valid(p0_output_valid), .p1_output_valid(p1_output_valid),
        .p0_action(p0_action), .p1_action(p1_action),
        .p0_make_bet(p0_make_bet), .p1_make_bet(p1_make_bet),
        .p0_request(p0_request), .p1_request(p1_request),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .p0_invalid(p0_invalid), .p1_invalid(p1_invalid),
        .p0_action_opponent(p0_action_opponent), .p1_action_opponent(p1_action_opponent),
        .p0_bet_opponent(p0_bet_opponent), .p1_bet_opponent(p1_bet_opponent),
        .money0(money0), .money1(money1), .pot_size(pot_size),
        .betting_round_done(betting_round_done), .hand_over(hand_over), .winner(winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                        input logic w);
        exp_t e;
        e.kind = k; e.pot = p; e.m0 = a; e.m1 = b; e.win = w;
        sb.push_back(e);
    endtask

    task automatic handle(input int k);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow observed=event%0d expected=none", k);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_pot", pot_size, e.pot);
            check("ev_money0", money0, e.m0);
            check("ev_money1", money1, e.m1);
            if (k == K_HAND) check("ev_winner", winner, e.win);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (p0_invalid) handle(K_INV0);
                if (p1_invalid) handle(K_INV1);
                if (betting_round_done) handle(K_DONE);
                if (hand_over) handle(K_HAND);
            end
        end
    end

    task automatic begin_round(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] p,
                               input logic f);
        @(negedge clk);
        stack0_in = s0; stack1_in = s1; pot_in = p; first_player = f; start_round = 1'b1;
        @(negedge clk);
        start_round = 1'b0;
    endtask

    task automatic move(input logic p, input logic [2:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!(p ? p1_request : p0_request) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("request_seen", (n < 60), 1);
        if (p) begin
            p1_output_valid = 1'b1; p1_action = a; p1_make_bet = b;
        end else begin
            p0_output_valid = 1'b1; p0_action = a; p0_make_bet = b;
        end
        n = 0;
        while (!(p ? p1_ack : p0_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", (n < 20), 1);
        p0_output_valid = 1'b0; p1_output_valid = 1'b0;
        p0_action = A_NONE; p1_action = A_NONE; p0_make_bet = 8'd0; p1_make_bet = 8'd0;
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b0; start_round = 1'b0; first_player = 1'b0;
        stack0_in = 8'd0; stack1_in = 8'd0; pot_in = 8'd0;
        p0_output_valid = 1'b0; p1_output_valid = 1'b0;
        p0_action = A_NONE; p1_action = A_NONE; p0_make_bet = 8'd0; p1_make_bet = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_money0", money0, 0);
        check("rst_pot", pot_size, 0);
        check("rst_p0_request", p0_request, 0);
        check("rst_p0_aop", p0_action_opponent, A_NONE);
        check("rst_done", betting_round_done, 0);
        rst = 1'b1;

        // Check-check round
        begin_round(8'd100, 8'd100, 8'd0, 1'b0);
        push(K_DONE, 8'd0, 8'd100, 8'd100, 1'b0);
        move(1'b0, A_CHECK, 8'd0);
        move(1'b1, A_CHECK, 8'd0);
        drain(20);
        check("t1_p0_aop", p0_action_opponent, A_CHECK);

        // Bet then call
        begin_round(8'd100, 8'd100, 8'd0, 1'b0);
        push(K_DONE, 8'd20, 8'd90, 8'd90, 1'b0);
        move(1'b0, A_BET, 8'd10);
        move(1'b1, A_CALL, 8'd0);
        drain(20);
        check("t2_p0_bop", p0_bet_opponent, 10);
        check("t2_p1_bop", p1_bet_opponent, 10);
        check("t2_p0_aop", p0_action_opponent, A_CALL);

        // Under-minimum raise rejected, then a legal raise and call
        begin_round(8'd100, 8'd100, 8'd0, 1'b0);
        move(1'b0, A_BET, 8'd10);
        push(K_INV1, 8'd10, 8'd90, 8'd100, 1'b0);
        move(1'b1, A_RAISE, 8'd11);
        check("t3_rerequest", p1_request, 1);
        check("t3_money1_kept", money1, 100);
        push(K_DONE, 8'd24, 8'd88, 8'd88, 1'b0);
        move(1'b1, A_RAISE, 8'd12);
        move(1'b0, A_CALL, 8'd0);
        drain(20);

        // Response timeout forces a fold
        begin_round(8'd100, 8'd100, 8'd0, 1'b0);
        push(K_HAND, 8'd5, 8'd95, 8'd100, 1'b0);
        move(1'b0, A_BET, 8'd5);
        drain(400);
        repeat (2) @(negedge clk);
        check("t4_winner_held", winner, 0);

        // All-in short of the raise still ends the round
        begin_round(8'd30, 8'd100, 8'd0, 1'b0);
        push(K_DONE, 8'd80, 8'd0, 8'd50, 1'b0);
        move(1'b0, A_BET, 8'd10);
        move(1'b1, A_RAISE, 8'd50);
        move(1'b0, A_ALLIN, 8'd0);
        drain(20);
        check("t5_p1_bop", p1_bet_opponent, 20);
        check("t5_p1_aop", p1_action_opponent, A_ALLIN);

        // Three illegal moves force a fold
        begin_round(8'd100, 8'd100, 8'd0, 1'b0);
        push(K_INV0, 8'd0, 8'd100, 8'd100, 1'b0);
        push(K_INV0, 8'd0, 8'd100, 8'd100, 1'b0);
        push(K_INV0, 8'd0, 8'd100, 8'd100, 1'b0);
        push(K_HAND, 8'd0, 8'd100, 8'd100, 1'b1);
        move(1'b0, A_NONE, 8'd0);
        move(1'b0, A_NONE, 8'd0);
        move(1'b0, A_NONE, 8'd0);
        drain(20);
        check("t6_winner", winner, 1);

        // Reset while a request is outstanding
        begin_round(8'd50, 8'd60, 8'd7, 1'b1);
        repeat (2) @(negedge clk);
        check("t7_p1_request", p1_request, 1);
        check("t7_pot_loaded", pot_size, 7);
        rst = 1'b0;
        #1;
        check("t7_rst_p1_request", p1_request, 0);
        check("t7_rst_money1", money1, 0);
        check("t7_rst_pot", pot_size, 0);
        check("t7_rst_winner", winner, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_idle_p0_request", p0_request, 0);
        check("t7_idle_p1_request", p1_request, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
